// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder: direction constants, FSM state
// encoding and default width parameters.
package mem_if_pkg;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 22;
    localparam int DEF_BURST_LEN     = 8;
    localparam int DEF_LATENCY       = 2;
    localparam int DEF_DEPTH_LOG2    = 10;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT        = 2'd1,
        WRITE_BURST = 2'd2,
        READ_BURST  = 2'd3
    } resp_state_t;

endpackage

// File: rtl/memory_responder_if.sv
// Initiator <-> responder burst bus. The initiator drives the i_MEM_* signals,
// the responder drives the o_MEM_* signals.
interface memory_responder_if
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
);
    logic                     i_MEM_Valid;
    logic [ADDRESS_WIDTH-1:0] i_MEM_Address;
    logic                     i_MEM_Read_Write_n;
    logic [DATA_WIDTH-1:0]    i_MEM_Data;
    logic                     o_MEM_Data_Read;
    logic [DATA_WIDTH-1:0]    o_MEM_Data;
    logic                     o_MEM_Data_Valid;
    logic                     o_MEM_Last;

    modport master (
        output i_MEM_Valid, i_MEM_Address, i_MEM_Read_Write_n, i_MEM_Data,
        input  o_MEM_Data_Read, o_MEM_Data, o_MEM_Data_Valid, o_MEM_Last
    );

    modport slave (
        input  i_MEM_Valid, i_MEM_Address, i_MEM_Read_Write_n, i_MEM_Data,
        output o_MEM_Data_Read, o_MEM_Data, o_MEM_Data_Valid, o_MEM_Last
    );
endinterface

// File: rtl/memory_responder_sram.sv
// Single-port backing store: synchronous write, one-cycle registered read,
// contents and read register are never reset.
module memory_responder_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_Clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] store [2**DEPTH_LOG2];

    always_ff @(posedge i_Clk) begin
        if (we)
            store[addr] <= wdata;
        rdata <= store[addr];
    end
endmodule

// File: rtl/memory_responder.sv
// Burst memory responder: accepts one request, waits LATENCY cycles, then moves
// BURST_LEN beats. Define MEMORY_RESPONDER_STALL_EN to add a bubble every 3rd beat.
module memory_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int BURST_LEN     = DEF_BURST_LEN,
    parameter int LATENCY       = DEF_LATENCY,
    parameter int DEPTH_LOG2    = DEF_DEPTH_LOG2
) (
    input  logic         i_Clk,
    input  logic         i_Reset_n,
    memory_responder_if.slave mem
);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int LAT_W  = $clog2(LATENCY + 1);

    resp_state_t           state;
    logic [LAT_W-1:0]      wait_cnt;
    logic [BEAT_W-1:0]     beat;
    logic [DEPTH_LOG2-1:0] addr;
    logic                  rw;
    logic                  data_read;
    logic                  data_valid;
    logic                  last;
`ifdef MEMORY_RESPONDER_STALL_EN
    logic [1:0]            phase;
`endif

    logic                  active;
    logic [DEPTH_LOG2-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] rd_q;

    // addr tracks the current beat; a read beat pre-fetches the next word,
    // while a bubble cycle re-issues the already-advanced address.
    assign active    = data_read | data_valid;
    assign sram_addr = (state == READ_BURST && active) ? addr + 1'b1 : addr;

    memory_responder_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .i_Clk (i_Clk),
        .we    (data_read),
        .addr  (sram_addr),
        .wdata (mem.i_MEM_Data),
        .rdata (rd_q)
    );

    // Gating by the reset-cleared valid flag zeroes the data bus on reset.
    assign mem.o_MEM_Data       = data_valid ? rd_q : '0;
    assign mem.o_MEM_Data_Read  = data_read;
    assign mem.o_MEM_Data_Valid = data_valid;
    assign mem.o_MEM_Last       = last;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            beat       <= '0;
            addr       <= '0;
            rw         <= READ;
            data_read  <= 1'b0;
            data_valid <= 1'b0;
            last       <= 1'b0;
`ifdef MEMORY_RESPONDER_STALL_EN
            phase      <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem.i_MEM_Valid) begin
                        addr     <= mem.i_MEM_Address[DEPTH_LOG2-1:0];
                        rw       <= mem.i_MEM_Read_Write_n;
                        wait_cnt <= LAT_W'(LATENCY);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAT_W'(1)) begin
                        state      <= (rw == READ) ? READ_BURST : WRITE_BURST;
                        data_read  <= (rw == WRITE);
                        data_valid <= (rw == READ);
                        beat       <= '0;
                        last       <= 1'b0;
`ifdef MEMORY_RESPONDER_STALL_EN
                        phase      <= 2'd0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                WRITE_BURST, READ_BURST: begin
                    if (active) begin
                        if (last) begin
                            state      <= IDLE;
                            data_read  <= 1'b0;
                            data_valid <= 1'b0;
                            last       <= 1'b0;
                        end else begin
                            beat <= beat + 1'b1;
                            addr <= addr + 1'b1;
`ifdef MEMORY_RESPONDER_STALL_EN
                            if (phase == 2'd2) begin
                                phase      <= 2'd0;
                                data_read  <= 1'b0;
                                data_valid <= 1'b0;
                            end else begin
                                phase <= phase + 2'd1;
                                last  <= (beat == BEAT_W'(BURST_LEN - 2));
                            end
`else
                            last <= (beat == BEAT_W'(BURST_LEN - 2));
`endif
                        end
                    end else begin
                        // bubble: resume with the beat already counted
                        data_read  <= (rw == WRITE);
                        data_valid <= (rw == READ);
                        last       <= (beat == BEAT_W'(BURST_LEN - 1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
